// File: rtl/mfp_ahb_interconnect_pkg.sv
// Shared constants and types for the MIPSfpga AHB-lite interconnect:
// HTRANS/HRESP encodings, default memory map and error-phase encoding.
package mfp_ahb_interconnect_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int N_SLAVES_MIN = 32'sd1;
    localparam int N_SLAVES_MAX = 32'sd8;
    localparam int N_SLAVES_DEF = 32'sd3;

    // Slave 0 is bits [31:0]: boot ROM, RAM, GPIO windows
    localparam logic [95:0] DEF_SLV_BASE = {32'h1F80_0000, 32'h0000_0000, 32'h1FC0_0000};
    localparam logic [95:0] DEF_SLV_MASK = {32'h1FC0_0000, 32'h1000_0000, 32'h1FC0_0000};

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_ONE  = 2'd1,
        ERR_TWO  = 2'd2
    } err_phase_e;

    function automatic logic htrans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/mfp_ahb_interconnect_if.sv
// Master-side and slave-side AHB-lite signals of the interconnect plus its
// decode-error diagnostics; the interconnect itself uses the slave modport.
interface mfp_ahb_interconnect_if
    import mfp_ahb_interconnect_pkg::*;
#(
    parameter int N_SLAVES = N_SLAVES_DEF
);
    logic [31:0]            HADDR;
    logic [1:0]             HTRANS;
    logic                   HWRITE;
    logic [31:0]            HRDATA;
    logic                   HREADY;
    logic                   HRESP;
    logic [N_SLAVES-1:0]    HSEL_S;
    logic [32*N_SLAVES-1:0] HRDATA_S;
    logic [N_SLAVES-1:0]    HREADYOUT_S;
    logic [N_SLAVES-1:0]    HRESP_S;
    logic [31:0]            ERR_ADDR;
    logic                   ERR_WRITE;
    logic [7:0]             ERR_CNT;

    modport master (
        output HADDR, HTRANS, HWRITE, HRDATA_S, HREADYOUT_S, HRESP_S,
        input  HRDATA, HREADY, HRESP, HSEL_S, ERR_ADDR, ERR_WRITE, ERR_CNT
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HRDATA_S, HREADYOUT_S, HRESP_S,
        output HRDATA, HREADY, HRESP, HSEL_S, ERR_ADDR, ERR_WRITE, ERR_CNT
    );
endinterface

// File: rtl/mfp_ahb_default_slave.sv
// Default slave for unmapped accesses: two-cycle AHB ERROR response and
// capture of the offending address, direction and a saturating error count.
module mfp_ahb_default_slave
    import mfp_ahb_interconnect_pkg::*;
(
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        start,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    output logic        ready,
    output logic        resp,
    output logic [31:0] err_addr,
    output logic        err_write,
    output logic [7:0]  err_cnt
);
    err_phase_e phase_r;
    err_phase_e phase_nxt_s;

    // Error phase sequencing and the response it presents
    always_comb begin
        phase_nxt_s = ERR_NONE;
        ready       = 1'b1;
        resp        = HRESP_OKAY;
        case (phase_r)
            ERR_NONE: phase_nxt_s = start ? ERR_ONE : ERR_NONE;
            ERR_ONE: begin
                phase_nxt_s = ERR_TWO;
                ready       = 1'b0;
                resp        = HRESP_ERROR;
            end
            ERR_TWO: begin
                phase_nxt_s = start ? ERR_ONE : ERR_NONE;
                resp        = HRESP_ERROR;
            end
            default: phase_nxt_s = ERR_NONE;
        endcase
    end

    // Error phase register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            phase_r <= ERR_NONE;
        end else begin
            phase_r <= phase_nxt_s;
        end
    end

    // Diagnostic capture on entry to the first error cycle
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_addr  <= 32'd0;
            err_write <= 1'b0;
            err_cnt   <= 8'd0;
        end else if (start) begin
            err_addr  <= haddr;
            err_write <= hwrite;
            err_cnt   <= sat_inc8(err_cnt);
        end else begin
            err_cnt   <= err_cnt;
        end
    end
endmodule

// File: rtl/mfp_ahb_interconnect.sv
// Single-master AHB-lite interconnect: base/mask address decode, data-phase
// slave select register and response mux, with a default slave for holes.
module mfp_ahb_interconnect
    import mfp_ahb_interconnect_pkg::*;
#(
    parameter int                     N_SLAVES = N_SLAVES_DEF,
    parameter logic [32*N_SLAVES-1:0] SLV_BASE = DEF_SLV_BASE,
    parameter logic [32*N_SLAVES-1:0] SLV_MASK = DEF_SLV_MASK
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    mfp_ahb_interconnect_if.slave bus
);
    // Selected slave stored as index+1 so that zero means "no slave"
    localparam int SEL_W = $clog2(N_SLAVES) + 1;

    logic [N_SLAVES-1:0] hsel_s;
    logic [SEL_W-1:0]    hit_sel_s;
    logic [SEL_W-1:0]    sel_r;
    logic [SEL_W-1:0]    sel_nxt_s;
    logic                hit_s;
    logic                active_s;
    logic                err_start_s;
    logic                err_ready_s;
    logic                err_resp_s;
    logic [31:0]         hrdata_s;
    logic                hready_s;
    logic                hresp_s;

    // Address decode; the lowest matching index wins
    always_comb begin
        hsel_s    = {N_SLAVES{1'b0}};
        hit_sel_s = {SEL_W{1'b0}};
        hit_s     = 1'b0;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (!hit_s && ((bus.HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32])) begin
                hsel_s[i] = 1'b1;
                hit_sel_s = SEL_W'(i + 1);
                hit_s     = 1'b1;
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    assign active_s    = htrans_active(bus.HTRANS);
    assign err_start_s = hready_s & active_s & ~hit_s;

    // Data-phase select reloads only when the current data phase completes
    always_comb begin
        sel_nxt_s = sel_r;
        if (hready_s) begin
            sel_nxt_s = (active_s && hit_s) ? hit_sel_s : {SEL_W{1'b0}};
        end else begin
            sel_nxt_s = sel_r;
        end
    end

    // Data-phase select register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_r <= {SEL_W{1'b0}};
        end else begin
            sel_r <= sel_nxt_s;
        end
    end

    // Response mux; with no slave selected the default slave answers
    always_comb begin
        hrdata_s = 32'd0;
        hready_s = err_ready_s;
        hresp_s  = err_resp_s;
        for (int i = 0; i < N_SLAVES; i++) begin
            if (sel_r == SEL_W'(i + 1)) begin
                hrdata_s = bus.HRDATA_S[32*i +: 32];
                hready_s = bus.HREADYOUT_S[i];
                hresp_s  = bus.HRESP_S[i];
            end else begin
                hrdata_s = hrdata_s;
            end
        end
    end

    mfp_ahb_default_slave u_default_slave (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .start     (err_start_s),
        .haddr     (bus.HADDR),
        .hwrite    (bus.HWRITE),
        .ready     (err_ready_s),
        .resp      (err_resp_s),
        .err_addr  (bus.ERR_ADDR),
        .err_write (bus.ERR_WRITE),
        .err_cnt   (bus.ERR_CNT)
    );

    assign bus.HSEL_S = hsel_s;
    assign bus.HRDATA = hrdata_s;
    assign bus.HREADY = hready_s;
    assign bus.HRESP  = hresp_s;
endmodule
